// File: rtl/parity_frame_checker_pkg.sv
// Shared types for the parity frame checker: FSM states, LRC reference value
// and the status flag record.
package parity_frame_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [7:0] LRC_ZERO = 8'h00;

  typedef struct packed {
    logic lrc_err;
    logic runt;
  } stat_flags_t;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Byte-stream input and frame-status output bundle of the parity frame checker.
interface parity_frame_checker_if #(
  parameter int LEN_W = 12,
  parameter int CNT_W = 8
) ();
  logic [7:0]       din;
  logic             pin;
  logic             dvalid;
  logic             dlast;
  logic             dready;
  logic             stat_valid;
  logic             stat_ready;
  logic [LEN_W-1:0] stat_len;
  logic [CNT_W-1:0] stat_byte_errs;
  logic             stat_lrc_err;
  logic             stat_runt;

  modport master (
    output din, pin, dvalid, dlast, stat_ready,
    input  dready, stat_valid, stat_len, stat_byte_errs, stat_lrc_err, stat_runt
  );

  modport slave (
    input  din, pin, dvalid, dlast, stat_ready,
    output dready, stat_valid, stat_len, stat_byte_errs, stat_lrc_err, stat_runt
  );
endinterface

// File: rtl/parity_frame_checker_xor8.sv
// Single 8-input XOR cell reducing one data byte to its parity.
module parity_frame_checker_xor8 (
  input  logic [7:0] d,
  output logic       p
);
  assign p = ^d;
endmodule

// File: rtl/parity_frame_checker.sv
// Per-byte parity and per-frame LRC checker; emits one status record per
// DLAST-terminated frame on a valid/ready port.
//
// state  | meaning
// IDLE   | no beat of the current frame accepted yet
// ACC    | mid-frame, accumulating LRC, length and bad-byte count
// REPORT | status record presented, input stalled until handshake
module parity_frame_checker
  import parity_frame_checker_pkg::*;
#(
  parameter logic ODD_PARITY = 1'b0,
  parameter int   CNT_W      = 8,
  parameter int   LEN_W      = 12
) (
  input logic                  clk,
  input logic                  rst,
  parity_frame_checker_if.slave bus
);

  state_t           state_q, state_d;
  logic [7:0]       lrc_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] errs_q;
  logic [LEN_W-1:0] stat_len_q;
  logic [CNT_W-1:0] stat_errs_q;
  stat_flags_t      stat_flags_q;

  logic             byte_par;
  logic             byte_bad;
  logic             accept;
  logic             stat_hs;
  logic [7:0]       lrc_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic [CNT_W-1:0] errs_nxt;

  parity_frame_checker_xor8 x_xor8 (
    .d (bus.din),
    .p (byte_par)
  );

  assign accept   = bus.dvalid & bus.dready;
  assign stat_hs  = bus.stat_valid & bus.stat_ready;
  assign byte_bad = byte_par ^ bus.pin ^ ODD_PARITY;
  assign lrc_nxt  = lrc_q ^ bus.din;
  // Both counters hold at all-ones rather than wrapping.
  assign len_nxt  = (len_q == '1) ? len_q : len_q + LEN_W'(1);
  assign errs_nxt = (byte_bad && (errs_q != '1)) ? errs_q + CNT_W'(1) : errs_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.dlast ? REPORT : ACC;
      ACC:     if (accept && bus.dlast) state_d = REPORT;
      REPORT:  if (stat_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.dready     = (state_q != REPORT);
    bus.stat_valid = (state_q == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lrc_q        <= LRC_ZERO;
      len_q        <= '0;
      errs_q       <= '0;
      stat_len_q   <= '0;
      stat_errs_q  <= '0;
      stat_flags_q <= '0;
    end else if (accept) begin
      lrc_q  <= lrc_nxt;
      len_q  <= len_nxt;
      errs_q <= errs_nxt;
      if (bus.dlast) begin
        stat_len_q           <= len_nxt;
        stat_errs_q          <= errs_nxt;
        stat_flags_q.lrc_err <= (lrc_nxt != LRC_ZERO);
        stat_flags_q.runt    <= (state_q == IDLE);
      end
    end else if (stat_hs) begin
      lrc_q  <= LRC_ZERO;
      len_q  <= '0;
      errs_q <= '0;
    end
  end

  assign bus.stat_len       = stat_len_q;
  assign bus.stat_byte_errs = stat_errs_q;
  assign bus.stat_lrc_err   = stat_flags_q.lrc_err;
  assign bus.stat_runt      = stat_flags_q.runt;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: expected status records are queued
// as frames are issued and checked by per-instance monitors on handshake.
module tb_parity_frame_checker;

  typedef struct {
    logic [11:0] len;
    logic [7:0]  errs;
    logic        lrc;
    logic        runt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;
  exp_t q0[$];
  exp_t q1[$];

  parity_frame_checker_if #(.LEN_W(12), .CNT_W(8)) bus0 ();
  parity_frame_checker_if #(.LEN_W(4),  .CNT_W(2)) bus1 ();

  parity_frame_checker #(.ODD_PARITY(1'b0), .CNT_W(8), .LEN_W(12)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  parity_frame_checker #(.ODD_PARITY(1'b1), .CNT_W(2), .LEN_W(4)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cmp_rec(input string name, input exp_t got, input exp_t want);
    n_vec++;
    if (got.len !== want.len || got.errs !== want.errs ||
        got.lrc !== want.lrc || got.runt !== want.runt) begin
      n_err++;
      $display("FAIL %s: got len=%0d errs=%0d lrc=%0b runt=%0b, want len=%0d errs=%0d lrc=%0b runt=%0b",
               name, got.len, got.errs, got.lrc, got.runt,
               want.len, want.errs, want.lrc, want.runt);
    end
  endtask

  always @(negedge clk) begin
    exp_t got;
    if (bus0.stat_valid === 1'b1 && bus0.stat_ready === 1'b1) begin
      got = '{bus0.stat_len, bus0.stat_byte_errs, bus0.stat_lrc_err, bus0.stat_runt};
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL status0_unexpected: got len=%0d, want no record", got.len);
      end else begin
        cmp_rec("status0", got, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t got;
    if (bus1.stat_valid === 1'b1 && bus1.stat_ready === 1'b1) begin
      got = '{12'(bus1.stat_len), 8'(bus1.stat_byte_errs), bus1.stat_lrc_err, bus1.stat_runt};
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL status1_unexpected: got len=%0d, want no record", got.len);
      end else begin
        cmp_rec("status1", got, q1.pop_front());
      end
    end
  end

  // Present one beat on bus0 and return #1 after the edge that transfers it.
  task automatic send_beat0(input logic [7:0] d, input logic p, input logic last);
    int w;
    w = 0;
    bus0.din    = d;
    bus0.pin    = p;
    bus0.dlast  = last;
    bus0.dvalid = 1'b1;
    while (bus0.dready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
      cyc++;
    end
    if (bus0.dready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL beat0_timeout: got dready=%b, want 1 within 20 cycles", bus0.dready);
    end else begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic idle0();
    bus0.dvalid = 1'b0;
    bus0.dlast  = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int w;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus0.din = '0; bus0.pin = 1'b0; bus0.dvalid = 1'b0; bus0.dlast = 1'b0; bus0.stat_ready = 1'b1;
    bus1.din = '0; bus1.pin = 1'b0; bus1.dvalid = 1'b0; bus1.dlast = 1'b0; bus1.stat_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_dready0",     32'(bus0.dready), 32'd1);
    chk("rst_svalid0",     32'(bus0.stat_valid), 32'd0);
    chk("rst_len0",        32'(bus0.stat_len), 32'd0);
    chk("rst_errs0",       32'(bus0.stat_byte_errs), 32'd0);
    chk("rst_lrc0",        32'(bus0.stat_lrc_err), 32'd0);
    chk("rst_runt0",       32'(bus0.stat_runt), 32'd0);
    chk("rst_dready1",     32'(bus1.dready), 32'd1);
    chk("rst_svalid1",     32'(bus1.stat_valid), 32'd0);
    @(posedge clk); #1;

    // 1: clean even-parity frame
    q0.push_back('{12'd3, 8'd0, 1'b0, 1'b0});
    send_beat0(8'h01, 1'b1, 1'b0);
    send_beat0(8'h03, 1'b0, 1'b0);
    send_beat0(8'h02, 1'b1, 1'b1);
    idle0();
    chk("t1_svalid_next", 32'(bus0.stat_valid), 32'd1);
    chk("t1_dready_low",  32'(bus0.dready), 32'd0);

    // 2: one parity error and a bad LRC byte
    q0.push_back('{12'd3, 8'd1, 1'b1, 1'b0});
    send_beat0(8'h01, 1'b1, 1'b0);
    send_beat0(8'h03, 1'b1, 1'b0);
    send_beat0(8'h03, 1'b0, 1'b1);
    idle0();

    // 3: single-beat frame with back-pressure on the status port
    @(posedge clk); #1;
    bus0.stat_ready = 1'b0;
    q0.push_back('{12'd1, 8'd0, 1'b0, 1'b1});
    send_beat0(8'h00, 1'b0, 1'b1);
    idle0();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_svalid", 32'(bus0.stat_valid), 32'd1);
      chk("t3_hold_dready", 32'(bus0.dready), 32'd0);
      chk("t3_hold_len",    32'(bus0.stat_len), 32'd1);
      chk("t3_hold_runt",   32'(bus0.stat_runt), 32'd1);
      chk("t3_hold_errs",   32'(bus0.stat_byte_errs), 32'd0);
      chk("t3_hold_lrc",    32'(bus0.stat_lrc_err), 32'd0);
    end
    @(posedge clk); #1;
    bus0.stat_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_after_dready", 32'(bus0.dready), 32'd1);
    chk("t3_after_svalid", 32'(bus0.stat_valid), 32'd0);

    // 4: odd parity, narrow counters, 20 bad beats saturate both counters
    q1.push_back('{12'hF, 8'h3, 1'b0, 1'b0});
    for (int i = 0; i < 20; i++) begin
      b = 8'(i);
      bus1.din    = b;
      bus1.pin    = ^b;
      bus1.dlast  = (i == 19);
      bus1.dvalid = 1'b1;
      w = 0;
      while (bus1.dready !== 1'b1 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (bus1.dready !== 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL beat1_timeout: got dready=%b, want 1 within 20 cycles", bus1.dready);
      end
      @(posedge clk); #1;
    end
    bus1.dvalid = 1'b0;
    bus1.dlast  = 1'b0;
    @(posedge clk); #1;

    // 5: reset mid-frame discards it; only the following frame reports
    send_beat0(8'h10, 1'b1, 1'b0);
    bus0.din = 8'h20; bus0.pin = 1'b1; bus0.dlast = 1'b0; bus0.dvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle0();
    chk("t5_post_rst_svalid", 32'(bus0.stat_valid), 32'd0);
    chk("t5_post_rst_len",    32'(bus0.stat_len), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("t5_quiet_svalid", 32'(bus0.stat_valid), 32'd0);
    q0.push_back('{12'd2, 8'd0, 1'b0, 1'b0});
    send_beat0(8'hAA, 1'b0, 1'b0);
    send_beat0(8'hAA, 1'b0, 1'b1);
    idle0();
    repeat (3) @(posedge clk); #1;

    // 6: back-to-back frames with DVALID held high, one bubble per frame
    q0.push_back('{12'd2, 8'd0, 1'b1, 1'b0});
    q0.push_back('{12'd2, 8'd0, 1'b0, 1'b0});
    q0.push_back('{12'd2, 8'd2, 1'b0, 1'b0});
    cyc = 0;
    send_beat0(8'h11, 1'b0, 1'b0);
    send_beat0(8'h22, 1'b0, 1'b1);
    send_beat0(8'h5A, 1'b0, 1'b0);
    send_beat0(8'h5A, 1'b0, 1'b1);
    send_beat0(8'h07, 1'b0, 1'b0);
    send_beat0(8'h07, 1'b0, 1'b1);
    idle0();
    chk("t6_cycles", 32'(cyc), 32'd8);

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (2) @(posedge clk); #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
